tcs3200_color_classifier: RTL and testbench

TCS3200_COLOR_CLASSIFIER -- requirements
Module: tcs3200_color_classifier

---
 rtl/tcs3200_color_classifier.sv | 217 +++++++++++++++++++++
 tb/tb_tcs3200_color_classifier.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tcs3200_color_classifier.sv
// TCS3200 colour sensor sequencer: per-channel gated edge counting and RGB classification.
// Define CLEAR_CHAN_EN to measure the clear channel and use it as a darkness override.
module tcs3200_color_classifier #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned WINDOW_CYCLES = 50000,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter logic [1:0]  FREQ_SCALE    = 2'b11,
  parameter logic [15:0] DARK_THRESH   = 16'd200,
  parameter logic [15:0] WHITE_THRESH  = 16'd4000,
  parameter logic [15:0] MARGIN        = 16'd100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sensor_out,
  output logic [1:0]       s2_s3,
  output logic [1:0]       s0_s1,
  output logic             luz,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] clear_cnt,
  output logic [2:0]       color,
  output logic             valid,
  output logic             ovf
);

  localparam int unsigned TMAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned CW   = (CNT_W > 16) ? CNT_W : 16;

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, CLASSIFY} state_t;
  typedef enum logic [1:0] {
    CH_RED = 2'b00, CH_BLUE = 2'b01, CH_CLEAR = 2'b10, CH_GREEN = 2'b11
  } chan_t;
  typedef enum logic [2:0] {
    COL_BLACK = 3'b000, COL_RED = 3'b001, COL_GREEN = 3'b010,
    COL_BLUE = 3'b011, COL_UNKNOWN = 3'b110, COL_WHITE = 3'b111
  } color_t;

  state_t           state, state_n;
  chan_t            chan, chan_n;
  logic [TW-1:0]    timer, timer_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] sh_r, sh_b;
`ifdef CLEAR_CHAN_EN
  logic [CNT_W-1:0] sh_c;
`endif
  logic             frame_ovf, sat;
  logic             sync1, sync2, sync_prev, rise;
  logic             settle_done, window_done, frame_done;
  logic [CW-1:0]    r_w, g_w, b_w, top, second, lo;
  color_t           lead_col, color_n;

  assign rise        = sync2 & ~sync_prev;
  assign settle_done = (timer == TW'(SETTLE_CYCLES - 1));
  assign window_done = (timer == TW'(WINDOW_CYCLES - 1));
  assign frame_done  = (state == COUNT) && window_done && (chan == CH_GREEN);
  assign s2_s3       = chan;
  assign s0_s1       = FREQ_SCALE;

  always_comb begin
    state_n = state;
    chan_n  = chan;
    timer_n = timer;
    case (state)
      IDLE: begin
        if (en) begin
          state_n = SETTLE;
          chan_n  = CH_RED;
          timer_n = '0;
        end
      end
      SETTLE: begin
        if (settle_done) begin
          state_n = COUNT;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      COUNT: begin
        if (window_done) begin
          timer_n = '0;
          if (chan == CH_GREEN) begin
            state_n = CLASSIFY;
          end else begin
            state_n = SETTLE;
            case (chan)
              CH_RED:  chan_n = CH_BLUE;
`ifdef CLEAR_CHAN_EN
              CH_BLUE: chan_n = CH_CLEAR;
`else
              CH_BLUE: chan_n = CH_GREEN;
`endif
              default: chan_n = CH_GREEN;
            endcase
          end
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      CLASSIFY: begin
        timer_n = '0;
        if (en) begin
          state_n = SETTLE;
          chan_n  = CH_RED;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // An edge arriving at full scale is dropped and flagged rather than wrapping.
  always_comb begin
    cnt_n = cnt;
    sat   = 1'b0;
    if (state == COUNT && rise) begin
      if (&cnt) sat = 1'b1;
      else      cnt_n = cnt + CNT_W'(1);
    end
  end

  // Green is always measured last, so its live count feeds the classifier on the final edge.
  always_comb begin
    r_w      = CW'(sh_r);
    g_w      = CW'(cnt_n);
    b_w      = CW'(sh_b);
    top      = r_w;
    second   = (g_w > b_w) ? g_w : b_w;
    lead_col = COL_RED;
    if (g_w > r_w && g_w >= b_w) begin
      top      = g_w;
      second   = (r_w > b_w) ? r_w : b_w;
      lead_col = COL_GREEN;
    end else if (b_w > r_w && b_w > g_w) begin
      top      = b_w;
      second   = (r_w > g_w) ? r_w : g_w;
      lead_col = COL_BLUE;
    end
    lo = r_w;
    if (g_w < lo) lo = g_w;
    if (b_w < lo) lo = b_w;
    if (top < CW'(DARK_THRESH))                                color_n = COL_BLACK;
    else if (lo >= CW'(WHITE_THRESH))                          color_n = COL_WHITE;
    else if (top == second || (top - second) < CW'(MARGIN))    color_n = COL_UNKNOWN;
    else                                                       color_n = lead_col;
`ifdef CLEAR_CHAN_EN
    if (CW'(sh_c) < CW'(DARK_THRESH)) color_n = COL_BLACK;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      chan      <= CH_RED;
      timer     <= '0;
      cnt       <= '0;
      sh_r      <= '0;
      sh_b      <= '0;
`ifdef CLEAR_CHAN_EN
      sh_c      <= '0;
      clear_cnt <= '0;
`endif
      frame_ovf <= 1'b0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      luz       <= 1'b0;
      red_cnt   <= '0;
      green_cnt <= '0;
      blue_cnt  <= '0;
      color     <= '0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_n;
      chan      <= chan_n;
      timer     <= timer_n;
      sync1     <= sensor_out;
      sync2     <= sync1;
      sync_prev <= sync2;
      luz       <= (state_n != IDLE);
      cnt       <= (state == SETTLE && settle_done) ? '0 : cnt_n;
      if (state == IDLE || state == CLASSIFY) frame_ovf <= 1'b0;
      else if (sat)                           frame_ovf <= 1'b1;
      if (state == COUNT && window_done) begin
        case (chan)
          CH_RED:   sh_r <= cnt_n;
          CH_BLUE:  sh_b <= cnt_n;
`ifdef CLEAR_CHAN_EN
          CH_CLEAR: sh_c <= cnt_n;
`endif
          default: ;
        endcase
      end
      valid <= frame_done;
      if (frame_done) begin
        red_cnt   <= sh_r;
        green_cnt <= cnt_n;
        blue_cnt  <= sh_b;
`ifdef CLEAR_CHAN_EN
        clear_cnt <= sh_c;
`endif
        color     <= color_n;
        ovf       <= frame_ovf | sat;
      end
    end
  end

`ifndef CLEAR_CHAN_EN
  assign clear_cnt = '0;
`endif

endmodule

// File: tb/tb_tcs3200_color_classifier.sv
// Directed bench for tcs3200_color_classifier: a sensor model emits a programmed pulse count per filter.
module tb_tcs3200_color_classifier;
  localparam int unsigned WIN = 100;
  localparam int unsigned SET = 4;
`ifdef CLEAR_CHAN_EN
  localparam bit HAS_CLEAR = 1'b1;
`else
  localparam bit HAS_CLEAR = 1'b0;
`endif
  localparam int unsigned NCH = HAS_CLEAR ? 4 : 3;
  localparam int NV = 13;

  typedef struct {
    string      name;
    int         kr;
    int         kg;
    int         kb;
    int         kc;
    logic [2:0] col;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, en_a, en_b;
  logic        sens [2];
  logic [1:0]  s23_a, s01_a, s23_b, s01_b;
  logic        luz_a, luz_b, valid_a, valid_b, ovf_a, ovf_b;
  logic [2:0]  color_a, color_b;
  logic [15:0] r_a, g_a, b_a, c_a;
  logic [3:0]  r_b, g_b, b_b, c_b;

  int         n_checks = 0;
  int         n_fail = 0;
  int         t [2];
  logic [1:0] psel [2];
  logic       pluz [2];
  int         kcfg [2][4];
  int         vcount [2];
  logic [1:0] seq_q [$];
  vec_t       vec [NV];

  always #5 clk = ~clk;

  tcs3200_color_classifier #(
    .CNT_W(16), .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .FREQ_SCALE(2'b11),
    .DARK_THRESH(16'd20), .WHITE_THRESH(16'd40), .MARGIN(16'd10)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .sensor_out(sens[0]), .s2_s3(s23_a), .s0_s1(s01_a),
    .luz(luz_a), .red_cnt(r_a), .green_cnt(g_a), .blue_cnt(b_a), .clear_cnt(c_a),
    .color(color_a), .valid(valid_a), .ovf(ovf_a)
  );

  tcs3200_color_classifier #(
    .CNT_W(4), .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .FREQ_SCALE(2'b11),
    .DARK_THRESH(16'd3), .WHITE_THRESH(16'd15), .MARGIN(16'd2)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .sensor_out(sens[1]), .s2_s3(s23_b), .s0_s1(s01_b),
    .luz(luz_b), .red_cnt(r_b), .green_cnt(g_b), .blue_cnt(b_b), .clear_cnt(c_b),
    .color(color_b), .valid(valid_b), .ovf(ovf_b)
  );

  // Sensor model: k rising edges at t = 2, 4, ... 2k after each filter change, which all land in the gate window.
  always @(negedge clk) begin
    logic [1:0] sel;
    logic       lz;
    for (int i = 0; i < 2; i++) begin
      sel = (i == 0) ? s23_a : s23_b;
      lz  = (i == 0) ? luz_a : luz_b;
      if (sel != psel[i] || (lz && !pluz[i])) begin
        t[i] = 0;
        if (i == 0 && lz) seq_q.push_back(sel);
      end else begin
        t[i] = t[i] + 1;
      end
      psel[i] = sel;
      pluz[i] = lz;
      sens[i] = (t[i] >= 2) && (t[i] <= 2 * kcfg[i][sel]) && (t[i] % 2 == 0);
      if (((i == 0) ? valid_a : valid_b) === 1'b1) vcount[i]++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_k(input int inst, input int kr, input int kg, input int kb, input int kc);
    kcfg[inst][0] = kr;
    kcfg[inst][1] = kb;
    kcfg[inst][2] = kc;
    kcfg[inst][3] = kg;
  endtask

  task automatic wait_valid(input int inst, input int limit, output int cyc);
    bit seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
      seen = (inst == 0) ? (valid_a === 1'b1) : (valid_b === 1'b1);
    end
    check($sformatf("valid_seen_%0d", inst), {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int v0;
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      t[i] = 0; psel[i] = 2'b00; pluz[i] = 1'b0; vcount[i] = 0; sens[i] = 1'b0;
      for (int j = 0; j < 4; j++) kcfg[i][j] = 0;
    end
    //            name            R   G   B   C   colour
    vec[0]  = '{"red_dom",       50,  5,  5, 30, 3'b001};
    vec[1]  = '{"all_dark",       5,  5,  5,  5, 3'b000};
    vec[2]  = '{"all_bright",    50, 50, 50, 50, 3'b111};
    vec[3]  = '{"near_tie",      50, 48,  5, 30, 3'b110};
    vec[4]  = '{"exact_tie",     50, 50,  5, 30, 3'b110};
    vec[5]  = '{"green_dom",      5, 45,  5, 30, 3'b010};
    vec[6]  = '{"blue_dom",      30,  5, 45, 30, 3'b011};
    vec[7]  = '{"clear_dark",    45,  5,  5,  5, HAS_CLEAR ? 3'b000 : 3'b001};
    vec[8]  = '{"margin_edge",   40, 30, 30, 30, 3'b001};
    vec[9]  = '{"margin_short",  39, 30, 30, 30, 3'b110};
    vec[10] = '{"dark_edge",     19, 10, 10, 30, 3'b000};
    vec[11] = '{"white_edge",    40, 40, 40, 30, 3'b111};
    vec[12] = '{"dark_min",      20,  5,  5, 30, 3'b001};

    repeat (3) @(posedge clk); #1;
    check("rst_s2_s3", s23_a, 0);
    check("rst_s0_s1", s01_a, 3);
    check("rst_luz", luz_a, 0);
    check("rst_red", r_a, 0);
    check("rst_green", g_a, 0);
    check("rst_blue", b_a, 0);
    check("rst_clear", c_a, 0);
    check("rst_color", color_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_red_b", r_b, 0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("idle_luz_off", luz_a, 0);

    set_k(0, vec[0].kr, vec[0].kg, vec[0].kb, vec[0].kc);
    @(negedge clk) en_a = 1'b1;
    for (int i = 0; i < NV; i++) begin
      wait_valid(0, 2000, cyc);
      if (i == 0) check("first_latency", cyc, NCH * (SET + WIN) + 1);
      check({vec[i].name, "_color"}, color_a, vec[i].col);
      check({vec[i].name, "_red"}, r_a, vec[i].kr);
      check({vec[i].name, "_green"}, g_a, vec[i].kg);
      check({vec[i].name, "_blue"}, b_a, vec[i].kb);
      check({vec[i].name, "_clear"}, c_a, HAS_CLEAR ? vec[i].kc : 0);
      check({vec[i].name, "_ovf"}, ovf_a, 0);
      if (i + 1 < NV) set_k(0, vec[i+1].kr, vec[i+1].kg, vec[i+1].kb, vec[i+1].kc);
      else            set_k(0, 50, 5, 5, 30);
      if (i == 0) begin
        v0 = 0;
        foreach (seq_q[j]) v0 = v0 * 4 + seq_q[j];
        check("chan_count", seq_q.size(), NCH);
        check("chan_order", v0, HAS_CLEAR ? 27 : 7);
        seq_q.delete();
        @(posedge clk); #1;
        check("valid_one_cycle", valid_a, 0);
        check("hold_red", r_a, 50);
        check("luz_between_frames", luz_a, 1);
      end
    end

    // Drop en mid-frame: the frame completes, then the block idles.
    repeat (150) @(posedge clk); #1;
    en_a = 1'b0;
    wait_valid(0, 2000, cyc);
    check("drop_red", r_a, 50);
    check("drop_color", color_a, 3'b001);
    @(posedge clk); #1;
    check("drop_luz_off", luz_a, 0);
    check("drop_valid_count", vcount[0], NV + 1);
    repeat (500) @(posedge clk); #1;
    check("drop_no_more_valid", vcount[0], NV + 1);
    check("drop_still_idle", luz_a, 0);

    // Reset during the blue window discards the frame.
    @(negedge clk) en_a = 1'b1;
    cyc = 0;
    while (s23_a !== 2'b01 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_blue", s23_a, 2'b01);
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_red", r_a, 0);
    check("arst_green", g_a, 0);
    check("arst_color", color_a, 0);
    check("arst_luz", luz_a, 0);
    check("arst_s2_s3", s23_a, 0);
    check("arst_valid", valid_a, 0);
    check("arst_ovf", ovf_a, 0);
    en_a = 1'b0;
    @(negedge clk) rst = 1'b0;
    v0 = vcount[0];
    repeat (600) @(posedge clk); #1;
    check("arst_no_valid", vcount[0], v0);
    set_k(0, vec[5].kr, vec[5].kg, vec[5].kb, vec[5].kc);
    @(negedge clk) en_a = 1'b1;
    wait_valid(0, 2000, cyc);
    en_a = 1'b0;
    check("restart_green", g_a, 45);
    check("restart_red", r_a, 5);
    check("restart_color", color_a, 3'b010);

    // 4-bit counters: saturation and ovf recovery.
    set_k(1, 50, 5, 5, 5);
    @(negedge clk) en_b = 1'b1;
    wait_valid(1, 2000, cyc);
    check("sat_red", r_b, 15);
    check("sat_green", g_b, 5);
    check("sat_ovf", ovf_b, 1);
    check("sat_color", color_b, 3'b001);
    set_k(1, 10, 5, 5, 5);
    wait_valid(1, 2000, cyc);
    check("nosat_red", r_b, 10);
    check("nosat_ovf", ovf_b, 0);
    check("nosat_color", color_b, 3'b001);
    set_k(1, 5, 50, 5, 5);
    wait_valid(1, 2000, cyc);
    en_b = 1'b0;
    check("sat_last_green", g_b, 15);
    check("sat_last_red", r_b, 5);
    check("sat_last_ovf", ovf_b, 1);
    check("sat_last_color", color_b, 3'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
